// File: rtl/dds_wave_reader.sv
// ============================================================================
// dds_wave_reader
// ----------------------------------------------------------------------------
// Read-side engine for the 64-entry waveform pROMs (sawtooth, sine, ...).
// A DDS phase accumulator picks the ROM address. A sample-rate divider sets
// how often a read is issued. Each ROM word comes back one cycle after its
// read and is captured into a 2-entry output FIFO. The FIFO feeds the DAC
// path over a valid/ready stream.
//
// Reads are only issued while there is credit: FIFO occupancy plus the read
// in flight, less a same-cycle pop, must leave room for the new word. A tick
// that finds no credit still advances the phase, but it issues no read and
// sets the sticky overrun flag.
//
// Ports
//   clk, rst_n     system clock; asynchronous active-low reset
//   en             run the divider and issue reads (0 = hold phase/divider)
//   ftw_in         frequency tuning word, latched on ftw_load
//   ftw_load       1-cycle pulse: latch ftw_in/div_in, restart the divider
//   div_in         tick period minus 1 (0 = tick every cycle)
//   phase_clr      1-cycle pulse: zero the phase accumulator
//   rom_ad         ROM address (top ADDR_W bits of the phase)
//   rom_ce         ROM clock enable, high only in read-issue cycles
//   rom_oce        ROM output clock enable, tied high (bypass read mode)
//   rom_reset      ROM reset, tied low
//   rom_dout       ROM data, valid the cycle after a rom_ce cycle
//   sample_data    head of the output FIFO
//   sample_valid   output FIFO non-empty
//   sample_ready   consumer accepts when sample_valid & sample_ready
//   overrun        sticky: a tick was dropped for lack of credit
//   overrun_clr    clears overrun (wins over a same-cycle set)
// ============================================================================
module dds_wave_reader #(
    parameter int unsigned PHASE_W = 32,
    parameter int unsigned ADDR_W  = 6,
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned DIV_W   = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    input  logic [PHASE_W-1:0]  ftw_in,
    input  logic                ftw_load,
    input  logic [DIV_W-1:0]    div_in,
    input  logic                phase_clr,
    output logic [ADDR_W-1:0]   rom_ad,
    output logic                rom_ce,
    output logic                rom_oce,
    output logic                rom_reset,
    input  logic [DATA_W-1:0]   rom_dout,
    output logic [DATA_W-1:0]   sample_data,
    output logic                sample_valid,
    input  logic                sample_ready,
    output logic                overrun,
    input  logic                overrun_clr
);

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [PHASE_W-1:0] phase_q,  phase_d;
    logic [PHASE_W-1:0] ftw_q,    ftw_d;
    logic [DIV_W-1:0]   div_q,    div_d;
    logic [DIV_W-1:0]   divcnt_q, divcnt_d;

    // Low during reset and for the first edge after release, so nothing is
    // issued while rst_n is asserted.
    logic               active_q, active_d;

    // A ROM read was issued last cycle; its data is on rom_dout now.
    logic               inflight_q, inflight_d;

    // 2-entry output FIFO
    logic [DATA_W-1:0]  buf0_q,   buf0_d;
    logic [DATA_W-1:0]  buf1_q,   buf1_d;
    logic               rd_ptr_q, rd_ptr_d;
    logic               wr_ptr_q, wr_ptr_d;
    logic [1:0]         count_q,  count_d;

    logic               overrun_q, overrun_d;

    // ------------------------------------------------------------------------
    // Combinational control
    // ------------------------------------------------------------------------
    logic               tick;
    logic               pop;
    logic               push;
    logic [1:0]         occupancy;
    logic               credit;
    logic               issue;
    logic [PHASE_W-1:0] phase_base;

    always_comb begin
        tick = en & active_q & (divcnt_q == div_q);
        pop  = (count_q != 2'd0) & sample_ready;
        push = inflight_q;

        // A pop in the same cycle frees a slot for the new read. Without it,
        // div=0 could not keep up one sample per cycle with only two entries.
        occupancy = count_q + 2'(inflight_q) - 2'(pop);
        credit    = (occupancy < 2'd2);
        issue     = tick & credit;

        // phase_clr coinciding with a tick makes that read use address 0.
        phase_base = phase_clr ? '0 : phase_q;
    end

    // The read is issued in the tick cycle itself, so the tick-to-valid
    // latency is 2 cycles: ROM data in T+1, captured at the end of T+1.
    assign rom_ad    = phase_base[PHASE_W-1 -: ADDR_W];
    assign rom_ce    = issue;
    assign rom_oce   = 1'b1;
    assign rom_reset = 1'b0;

    // ------------------------------------------------------------------------
    // Tuning registers and divider
    // ------------------------------------------------------------------------
    always_comb begin
        ftw_d    = ftw_q;
        div_d    = div_q;
        divcnt_d = divcnt_q;
        active_d = 1'b1;

        if (ftw_load) begin
            ftw_d = ftw_in;
            div_d = div_in;
        end

        if (ftw_load) begin
            divcnt_d = '0;
        end else if (tick) begin
            divcnt_d = '0;
        end else if (en && active_q) begin
            divcnt_d = divcnt_q + DIV_W'(1);
        end
    end

    // ------------------------------------------------------------------------
    // Phase accumulator
    // ------------------------------------------------------------------------
    always_comb begin
        phase_d = phase_q;
        if (tick) begin
            // Advances on every tick, with or without credit; wrap is silent.
            phase_d = phase_base + ftw_q;
        end else if (phase_clr) begin
            phase_d = '0;
        end
    end

    // ------------------------------------------------------------------------
    // Read pipeline and output FIFO
    // ------------------------------------------------------------------------
    always_comb begin
        inflight_d = issue;

        buf0_d   = buf0_q;
        buf1_d   = buf1_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;

        if (push) begin
            if (wr_ptr_q) begin
                buf1_d = rom_dout;
            end else begin
                buf0_d = rom_dout;
            end
            wr_ptr_d = ~wr_ptr_q;
        end

        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end

        count_d = count_q + 2'(push) - 2'(pop);
    end

    assign sample_data  = rd_ptr_q ? buf1_q : buf0_q;
    assign sample_valid = (count_q != 2'd0);

    // ------------------------------------------------------------------------
    // Overrun flag
    // ------------------------------------------------------------------------
    always_comb begin
        overrun_d = overrun_q;
        if (overrun_clr) begin
            overrun_d = 1'b0;
        end else if (tick && !credit) begin
            overrun_d = 1'b1;
        end
    end

    assign overrun = overrun_q;

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q    <= '0;
            ftw_q      <= '0;
            div_q      <= '0;
            divcnt_q   <= '0;
            active_q   <= 1'b0;
            inflight_q <= 1'b0;
            buf0_q     <= '0;
            buf1_q     <= '0;
            rd_ptr_q   <= 1'b0;
            wr_ptr_q   <= 1'b0;
            count_q    <= '0;
            overrun_q  <= 1'b0;
        end else begin
            phase_q    <= phase_d;
            ftw_q      <= ftw_d;
            div_q      <= div_d;
            divcnt_q   <= divcnt_d;
            active_q   <= active_d;
            inflight_q <= inflight_d;
            buf0_q     <= buf0_d;
            buf1_q     <= buf1_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            overrun_q  <= overrun_d;
        end
    end

endmodule
